// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the memory-stage load/store unit.
package mem_access_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
    localparam logic [BE_W-1:0] BE_BYTE0   = 4'b1000;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

    // Size encoding 2'b10 is treated as a word access, same as SIZE_WORD.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = offset[0];
            default:   mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: store byte enables/replication and load extract/extend.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_offset,
    input  logic [DATA_W-1:0] st_data,
    output logic [BE_W-1:0]   be_c,
    output logic [DATA_W-1:0] wdata_c,
    input  logic [1:0]        ld_size,
    input  logic [1:0]        ld_offset,
    input  logic              ld_unsigned,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ld_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Byte enables and lane-replicated write data for the presented access.
    always_comb begin
        be_c    = BE_WORD;
        wdata_c = st_data;
        case (st_size)
            SIZE_BYTE: begin
                be_c    = BE_BYTE0 >> st_offset;
                wdata_c = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                be_c    = st_offset[1] ? BE_HALF_LO : BE_HALF_HI;
                wdata_c = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Select the addressed byte and half; offset 0 is the most significant lane.
    always_comb begin
        ld_byte = rdata[7:0];
        case (ld_offset)
            2'd0:    ld_byte = rdata[31:24];
            2'd1:    ld_byte = rdata[23:16];
            2'd2:    ld_byte = rdata[15:8];
            default: ld_byte = rdata[7:0];
        endcase
        ld_half = ld_offset[1] ? rdata[15:0] : rdata[31:16];
    end

    // Sign- or zero-extend sub-word loads; words pass through untouched.
    always_comb begin
        ld_data_c = rdata;
        case (ld_size)
            SIZE_BYTE: ld_data_c = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
            SIZE_HALF: ld_data_c = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
            default:   ld_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one registered bus transaction per access, stalling the pipeline.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              MemoryRE,
    input  logic              MemoryWE,
    input  logic [1:0]        SizeOut,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] StoreData,
    output logic              Stall,
    output logic [DATA_W-1:0] LoadData,
    output logic              AddressError,
    output logic [ADDR_W-1:0] BusAddr,
    output logic              BusRE,
    output logic              BusWE,
    output logic [BE_W-1:0]   BusByteEnable,
    output logic [DATA_W-1:0] BusWriteData,
    input  logic              BusReady,
    input  logic [DATA_W-1:0] BusReadData
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              uns_q, uns_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] load_q, load_d;

    logic              req_c;
    logic              misaligned_c;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] ld_data_c;

    assign req_c        = MemoryRE | MemoryWE;
    assign misaligned_c = is_misaligned(SizeOut, Address[1:0]);

    mem_lane_align u_align (
        .st_size     (SizeOut),
        .st_offset   (Address[1:0]),
        .st_data     (StoreData),
        .be_c        (be_c),
        .wdata_c     (wdata_c),
        .ld_size     (size_q),
        .ld_offset   (off_q),
        .ld_unsigned (uns_q),
        .rdata       (BusReadData),
        .ld_data_c   (ld_data_c)
    );

    // Next-state, captured transaction fields, and the combinational stall/error strobes.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        re_d         = re_q;
        we_d         = we_q;
        load_d       = load_q;
        Stall        = 1'b0;
        AddressError = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    if (misaligned_c) begin
                        AddressError = 1'b1;
                    end else begin
                        Stall   = 1'b1;
                        addr_d  = {Address[ADDR_W-1:2], 2'b00};
                        be_d    = be_c;
                        wdata_d = wdata_c;
                        size_d  = SizeOut;
                        off_d   = Address[1:0];
                        uns_d   = Unsigned;
                        we_d    = MemoryWE;
                        re_d    = ~MemoryWE;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                Stall = 1'b1;
                if (BusReady) begin
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_DONE;
                    if (re_q) begin
                        load_d = ld_data_c;
                    end
                end
            end
            // The access still presented here belongs to the completing instruction.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and transaction registers; reset drops any in-flight request at once.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= BE_NONE;
            wdata_q <= '0;
            size_q  <= SIZE_BYTE;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            re_q    <= re_d;
            we_q    <= we_d;
            load_q  <= load_d;
        end
    end

    assign BusAddr       = addr_q;
    assign BusByteEnable = be_q;
    assign BusWriteData  = wdata_q;
    assign BusRE         = re_q;
    assign BusWE         = we_q;
    assign LoadData      = load_q;

endmodule
